// File: rtl/slave_arbiter.sv
// Per-slave arbiter: round-robin ownership of one slave port with a burst cap,
// sequencing each transfer through ADDR and DATA phases and stalling the losing masters.
module slave_arbiter #(
  parameter int  NUM_MASTERS = 2,
  parameter int  MAX_BURST   = 4,
  localparam int OWN_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_MASTERS-1:0] i_hselx,
  input  logic [NUM_MASTERS-1:0] i_htrans,
  input  logic                   i_slave_hready,
  output logic [NUM_MASTERS-1:0] o_bus_grant,
  output logic [NUM_MASTERS-1:0] o_hready_m,
  output logic [OWN_W-1:0]       o_data_owner,
  output logic                   o_busy
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OWN_W-1:0]       owner_q, owner_d;
  logic [OWN_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] req, req_m, own_mask;
  logic                   cap_hit;
  logic                   win_vld;
  logic [OWN_W-1:0]       win_idx;
  logic [CNT_W-1:0]       cnt_next;
  logic                   take;

  assign req = i_hselx & i_htrans;

  // The owner at the burst cap is masked out only while someone else is asking.
  always_comb begin
    own_mask = NUM_MASTERS'(1) << last_q;
    cap_hit  = (cnt_q == CNT_CAP) && (|(req & ~own_mask));
    req_m    = cap_hit ? (req & ~own_mask) : req;
    win_vld  = 1'b0;
    win_idx  = '0;
    // Walk from farthest to nearest so the first requester after last_q ends up winning.
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_MASTERS;
      if (req_m[idx]) begin
        win_vld = 1'b1;
        win_idx = OWN_W'(idx);
      end
    end
    if (win_idx == last_q)
      cnt_next = (cnt_q == CNT_CAP) ? CNT_CAP : cnt_q + CNT_W'(1);
    else
      cnt_next = CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: take = win_vld;
      ADDR: state_d = DATA;
      DATA: begin
        if (i_slave_hready) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (take) begin
      state_d = ADDR;
      grant_d = NUM_MASTERS'(1) << win_idx;
      owner_d = win_idx;
      last_d  = win_idx;
      cnt_d   = cnt_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OWN_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    o_hready_m = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i_rst || !req[i])
        o_hready_m[i] = 1'b1;
      else if ((state_q == DATA) && (owner_q == OWN_W'(i)))
        o_hready_m[i] = i_slave_hready;
      else
        o_hready_m[i] = 1'b0;
    end
  end

  assign o_bus_grant  = grant_q;
  assign o_data_owner = owner_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_slave_arbiter.sv
// Directed bench for slave_arbiter: a 2-master instance driven from a vector table and a
// 3-master instance with a burst cap of 2 driven by a hand-written sequence.
module tb_slave_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [1:0] a_sel, a_trans;
  logic [1:0] a_grant, a_hrm, a_owner_w;
  logic       a_owner, a_busy;
  logic [2:0] b_sel, b_trans;
  logic [2:0] b_grant, b_hrm;
  logic [1:0] b_owner;
  logic       b_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slave_arbiter #(.NUM_MASTERS(2), .MAX_BURST(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_hselx(a_sel), .i_htrans(a_trans),
    .i_slave_hready(rdy), .o_bus_grant(a_grant), .o_hready_m(a_hrm),
    .o_data_owner(a_owner), .o_busy(a_busy)
  );

  slave_arbiter #(.NUM_MASTERS(3), .MAX_BURST(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_hselx(b_sel), .i_htrans(b_trans),
    .i_slave_hready(rdy), .o_bus_grant(b_grant), .o_hready_m(b_hrm),
    .o_data_owner(b_owner), .o_busy(b_busy)
  );

  assign a_owner_w = {1'b0, a_owner};

  typedef struct {
    logic       rst;
    logic [1:0] sel;
    logic [1:0] trans;
    logic       rdy;
    logic [1:0] g;
    logic [1:0] hrm;
    logic       busy;
    logic       own;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [1:0] s, input logic [1:0] t, input logic y,
                     input logic [1:0] g, input logic [1:0] h, input logic b, input logic o);
    vec_t v;
    v.rst = r; v.sel = s; v.trans = t; v.rdy = y;
    v.g = g; v.hrm = h; v.busy = b; v.own = o;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_b(input logic [2:0] r);
    @(posedge clk);
    #1;
    b_sel   = r;
    b_trans = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    a_sel = '0; a_trans = '0; b_sel = '0; b_trans = '0;

    //   rst  sel    trans  rdy  grant  hrm    busy own
    add(1, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0, 0);   // reset, idle
    add(0, 2'b10, 2'b10, 1, 2'b00, 2'b01, 0, 0);   // M1 alone from IDLE
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b01, 1, 1);   // ADDR
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b11, 1, 1);   // DATA, completes
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b01, 1, 1);
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b11, 1, 1);
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b01, 1, 1);
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b11, 1, 1);
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b01, 1, 1);
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b11, 1, 1);   // burst count saturated
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b01, 1, 1);
    add(0, 2'b00, 2'b00, 1, 2'b10, 2'b11, 1, 1);   // last DATA, no requests
    add(0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0, 1);   // IDLE, owner held
    add(0, 2'b11, 2'b11, 1, 2'b00, 2'b00, 0, 1);   // both request
    add(0, 2'b11, 2'b11, 1, 2'b01, 2'b00, 1, 0);
    add(0, 2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 0);
    add(0, 2'b11, 2'b11, 1, 2'b10, 2'b00, 1, 1);
    add(0, 2'b11, 2'b11, 1, 2'b10, 2'b10, 1, 1);
    add(0, 2'b11, 2'b11, 1, 2'b01, 2'b00, 1, 0);
    add(0, 2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 0);
    add(0, 2'b11, 2'b11, 1, 2'b10, 2'b00, 1, 1);
    add(0, 2'b01, 2'b01, 1, 2'b10, 2'b10, 1, 1);   // M1 done, M0 next
    add(0, 2'b01, 2'b01, 1, 2'b01, 2'b10, 1, 0);
    add(0, 2'b01, 2'b01, 0, 2'b01, 2'b10, 1, 0);   // wait state 1
    add(0, 2'b11, 2'b11, 0, 2'b01, 2'b00, 1, 0);   // wait 2, M1 arrives
    add(0, 2'b11, 2'b11, 0, 2'b01, 2'b00, 1, 0);   // wait 3
    add(0, 2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 0);   // completion
    add(0, 2'b10, 2'b10, 1, 2'b10, 2'b01, 1, 1);   // M1 ADDR right after
    add(0, 2'b01, 2'b01, 1, 2'b10, 2'b10, 1, 1);
    add(0, 2'b01, 2'b00, 1, 2'b01, 2'b11, 1, 0);   // M0 drops htrans in ADDR
    add(0, 2'b00, 2'b00, 0, 2'b01, 2'b11, 1, 0);   // DATA still happens
    add(0, 2'b00, 2'b00, 1, 2'b01, 2'b11, 1, 0);
    add(0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0, 0);   // back to IDLE
    add(0, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0);
    add(0, 2'b11, 2'b11, 0, 2'b10, 2'b00, 1, 1);
    add(0, 2'b11, 2'b11, 0, 2'b10, 2'b00, 1, 1);   // DATA stalled
    add(1, 2'b11, 2'b11, 0, 2'b10, 2'b11, 1, 1);   // reset mid-transfer
    add(0, 2'b00, 2'b00, 1, 2'b00, 2'b11, 0, 0);
    add(0, 2'b11, 2'b11, 1, 2'b00, 2'b00, 0, 0);   // M0 first again
    add(0, 2'b11, 2'b11, 1, 2'b01, 2'b00, 1, 0);

    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      rst = vq[i].rst; a_sel = vq[i].sel; a_trans = vq[i].trans; rdy = vq[i].rdy;
      @(negedge clk);
      chk("grant",    i, 32'(a_grant),   32'(vq[i].g));
      chk("hready_m", i, 32'(a_hrm),     32'(vq[i].hrm));
      chk("busy",     i, 32'(a_busy),    32'(vq[i].busy));
      chk("owner",    i, 32'(a_owner_w), 32'(vq[i].own));
    end

    // Three masters, burst cap 2: M0 streams, M1 joins during M0's third grant.
    @(posedge clk);
    #1;
    rst = 1'b0; rdy = 1'b1; a_sel = '0; a_trans = '0;
    drive_b(3'b001);
    chk("b_idle_busy", 0, 32'(b_busy), 32'd0);
    chk("b_idle_grant", 0, 32'(b_grant), 32'd0);
    drive_b(3'b001);
    chk("b_grant1", 1, 32'(b_grant), 32'b001);
    drive_b(3'b001);
    chk("b_hrm_data1", 2, 32'(b_hrm), 32'b111);
    drive_b(3'b001);
    chk("b_grant2", 3, 32'(b_grant), 32'b001);
    drive_b(3'b001);
    drive_b(3'b011);
    chk("b_grant3", 5, 32'(b_grant), 32'b001);
    chk("b_hrm_addr3", 5, 32'(b_hrm), 32'b100);
    drive_b(3'b011);
    chk("b_hrm_data3", 6, 32'(b_hrm), 32'b101);
    chk("b_owner3", 6, 32'(b_owner), 32'd0);
    drive_b(3'b011);
    chk("b_grant_m1", 7, 32'(b_grant), 32'b010);
    chk("b_owner_m1", 7, 32'(b_owner), 32'd1);
    drive_b(3'b011);
    chk("b_hrm_m1_data", 8, 32'(b_hrm), 32'b110);
    drive_b(3'b011);
    chk("b_grant_back_m0", 9, 32'(b_grant), 32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
